// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine writing {HI,LO}; define MULDIV_FAST_MULT_EN for single-cycle multiplies.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 flush,
  output logic                 stall,
  output logic                 busy,
  output logic                 hilo_we,
  output logic [2*WIDTH-1:0]   result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic is_div, neg_hi, neg_lo, accept, last, fast, sa, sb;
  logic [WIDTH-1:0] md, mag_a, mag_b;
  logic [WIDTH:0] mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] acc, acc_nx, fin, prod;
  assign sa = ~op[0] & a[WIDTH-1];
  assign sb = ~op[0] & b[WIDTH-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;
`ifdef MULDIV_FAST_MULT_EN
  assign fast = ~op[1];
  assign prod = {{WIDTH{sa}}, a} * {{WIDTH{sb}}, b};
`else
  assign fast = 1'b0;
  assign prod = '0;
`endif
  assign accept = (state == IDLE) & start & ~flush;
  assign last = (state == CALC) & (cnt == CW'(WIDTH - 1));
  assign busy = (state == CALC);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = flush ? IDLE :
               state == IDLE ? (accept ? (fast ? DONE : CALC) : IDLE) :
               state == CALC ? (last ? DONE : CALC) : IDLE;
  always_comb
    stall = (state == CALC) | accept;
  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? md : '0};
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = rem_sh - {1'b0, md};
    acc_nx = is_div ? {diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]}
                    : {mul_sum, acc[WIDTH-1:1]};
    fin = is_div ? {neg_hi ? -acc_nx[2*WIDTH-1:WIDTH] : acc_nx[2*WIDTH-1:WIDTH],
                    neg_lo ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0]}
                 : (neg_lo ? -acc_nx : acc_nx);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      is_div <= 1'b0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
      md <= '0;
      acc <= '0;
      result <= '0;
      hilo_we <= 1'b0;
    end else begin
      hilo_we <= 1'b0;
      if (accept) begin
        cnt <= '0;
        is_div <= op[1];
        md <= mag_b;
        acc <= {{WIDTH{1'b0}}, mag_a};
        neg_hi <= sa;
        // divide-by-zero keeps the raw all-ones quotient unsigned
        neg_lo <= (sa ^ sb) & (~op[1] | (|b));
        if (fast) begin
          result <= prod;
          hilo_we <= 1'b1;
        end
      end else if (busy & ~flush) begin
        cnt <= cnt + 1'b1;
        acc <= acc_nx;
        if (last) begin
          result <= fin;
          hilo_we <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven check of muldiv_unit results, latency, flush, reset and held-start behaviour.
module tb_muldiv_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic stall, busy, hilo_we;
  logic [63:0] result;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[11];
  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .stall(stall), .busy(busy), .hilo_we(hilo_we), .result(result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic int lat_of(input logic [1:0] o);
`ifdef MULDIV_FAST_MULT_EN
    return o[1] ? 33 : 1;
`else
    return 33;
`endif
  endfunction
  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [63:0] exp, input string nm);
    int n = 0;
    bit got = 0;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    chk({nm, " stall_accept"}, 64'(stall), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (hilo_we) got = 1;
    end
    chk({nm, " latency"}, 64'(n), 64'(lat_of(o)));
    chk({nm, " result"}, result, exp);
    @(negedge clk);
    chk({nm, " we_pulse"}, 64'(hilo_we), 64'd0);
  endtask
  initial begin
    int pulses, p1, p2;
    logic [63:0] held;
    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB};
    vecs[2]  = '{2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD};
    vecs[4]  = '{2'b11, 32'd100,      32'd7,        64'h00000002_0000000E};
    vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
    vecs[6]  = '{2'b11, 32'd5,        32'd0,        64'h00000005_FFFFFFFF};
    vecs[7]  = '{2'b10, 32'hFFFFFFF0, 32'd0,        64'hFFFFFFF0_FFFFFFFF};
    vecs[8]  = '{2'b00, 32'h12345678, 32'hFFFFFFFF, 64'hFFFFFFFF_EDCBA988};
    vecs[9]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
    vecs[10] = '{2'b01, 32'h00010000, 32'h00010000, 64'h00000001_00000000};
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset we", 64'(hilo_we), 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    for (int i = 0; i < 11; i++)
      run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    // flush mid-CALC: start at cycle 0, flush in cycle 10
    held = result;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush busy_c10", 64'(busy), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush busy_c11", 64'(busy), 64'd0);
    chk("flush stall_c11", 64'(stall), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (hilo_we) pulses++;
    end
    chk("flush no_we", 64'(pulses), 64'd0);
    chk("flush result_kept", result, held);
    run(2'b11, 32'd1000, 32'd3, 64'h00000001_0000014D, "after_flush");
    // asynchronous reset mid-CALC
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; a = 32'd50; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst we", 64'(hilo_we), 64'd0);
    chk("rst result", result, 64'd0);
    chk("rst stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(2'b10, 32'd50, 32'hFFFFFFFB, 64'h00000000_FFFFFFF6, "after_rst");
    // start held through cycles 0..34 by a stalled pipeline
    pulses = 0; p1 = -1; p2 = -1;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    for (int c = 0; c <= 80; c++) begin
      @(negedge clk);
      if (hilo_we) begin
        pulses++;
        if (pulses == 1) p1 = c;
        else if (pulses == 2) p2 = c;
      end
      @(posedge clk); #1;
      if (c == 34) start = 1'b0;
    end
    chk("held pulses", 64'(pulses), 64'd2);
    chk("held first", 64'(p1), 64'd33);
    chk("held second", 64'(p2), 64'd67);
    chk("held result", result, 64'h00000002_0000000E);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide engine in the execute stage that produces the 64-bit {HI,LO} write for the HI/LO register. It accepts one MULT/MULTU/DIV/DIVU operation at a time and computes it iteratively. It stalls the pipeline while busy, then pulses a one-cycle write strobe with the 64-bit result. It is the writer side of the HI/LO interface: `result` drives `hilo_in` and `hilo_we` drives `we`.

## Interface
Parameters:
- `WIDTH`, 32, operand width; result is 2*WIDTH.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: E-stage instruction is a mul/div; sampled only in IDLE.
- `op`, in, 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `a`, in, WIDTH: rs operand (multiplicand / dividend).
- `b`, in, WIDTH: rt operand (multiplier / divisor).
- `flush`, in, 1: synchronous abort of any in-flight operation.
- `stall`, out, 1: combinational freeze request to the pipeline.
- `busy`, out, 1: registered; high while in CALC.
- `hilo_we`, out, 1: registered one-cycle write strobe to HI/LO.
- `result`, out, 2*WIDTH: registered {HI,LO}; valid when `hilo_we`=1, held until the next accepted start.

## Operation
- State machine: IDLE -> CALC -> DONE -> IDLE.
- IDLE -> CALC when `start`=1 and `flush`=0. Operands, op and sign info are latched; the 5-bit iteration counter is cleared.
- CALC: one radix-2 step per cycle. Leave to DONE after the 32nd step (counter==31).
- DONE: `hilo_we`=1 for exactly this cycle, then IDLE unconditionally. `start` is ignored in DONE; it is the same instruction, which is leaving E on this edge.
- `stall` = (state==CALC) | (state==IDLE & start & ~flush).
- Multiply: shift-add on operand magnitudes giving a 64-bit product. For MULT, negate the 64-bit product if a[31]^b[31].
- Divide: restoring division on magnitudes.
  - Quotient is negated if the signs differ (DIV).
  - Remainder takes the sign of the dividend (DIV).
  - HI=remainder, LO=quotient.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (b==0, DIV or DIVU): full latency still taken; HI=a, LO=0xFFFFFFFF.
- `start` during CALC or DONE: ignored; no second operation.
- `flush` in any state: next state IDLE, `hilo_we` stays 0, `result` is unchanged. `flush` beats `start` in the same cycle.
- `rst` asserted in any state: immediately IDLE, counter=0, all internal registers cleared.

## Timing
- Reset values: `busy`=0, `hilo_we`=0, `result`=0, `stall`=0 (given `start`=0).
- `start` accepted at cycle 0 (stall=1).
- CALC occupies cycles 1..32 (busy=1, stall=1).
- DONE is cycle 33: stall=0, hilo_we=1, result valid.
- HI/LO updates at the end of cycle 33. Total latency is 33 cycles from start to write strobe.
- Back-to-back operations: the next start is accepted in the IDLE cycle after DONE (cycle 34).
- MFHI/MFLO forwarding is outside this block. The pipeline keeps the consumer stalled via `stall` until the write completes.

## Configuration
- `MULDIV_FAST_MULT_EN` defined:
  - MULT/MULTU compute in one cycle with a single-cycle `*` into `result`.
  - IDLE goes directly to DONE, with `hilo_we` at cycle 1.
  - `stall` is high only in the accept cycle.
  - Divides are unchanged (33-cycle latency).
- Not defined: multiplies use the 32-step iterative path with the same 33-cycle timing as divides.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> at cycle 33 `hilo_we`=1, `result`=0xFFFFFFFE_00000001; cycle 1 with `MULDIV_FAST_MULT_EN`.
- MULT a=0xFFFFFFFD (-3) b=7 -> `result`=0xFFFFFFFF_FFFFFFEB. MULT 0x80000000*0x80000000 -> 0x40000000_00000000.
- DIV a=0xFFFFFFF9 (-7) b=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD. DIVU 100/7 -> HI=2, LO=14. DIV 0x80000000/0xFFFFFFFF -> HI=0, LO=0x80000000.
- DIVU a=5 b=0 -> cycle 33 HI=5, LO=0xFFFFFFFF. DIV a=0xFFFFFFF0 b=0 -> HI=0xFFFFFFF0, LO=0xFFFFFFFF.
- Abort: start DIVU, assert `flush` at cycle 10 -> cycle 11 `busy`=0, no `hilo_we` ever, `result` unchanged. New start at cycle 12 completes at cycle 45. Repeat with `rst` pulsed mid-CALC -> all outputs 0 asynchronously.
- Start held high for cycles 0..33 (stalled instruction) -> exactly one `hilo_we` pulse (cycle 33). Start re-asserted at cycle 34 -> second pulse at cycle 67.
